main_ctrl_unit: RTL and testbench



---
 rtl/main_ctrl_pkg.sv | 20 ++
 rtl/main_ctrl_unit_median9.sv | 36 +++
 rtl/main_ctrl_unit.sv | 86 ++++++++
 tb/tb_main_ctrl_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/main_ctrl_pkg.sv
// Shared types and constants for the 3x3 streaming pixel filter.
package main_ctrl_pkg;

  localparam int PW  = 5;
  localparam int WIN = 3;

  typedef logic [PW-1:0] pixel_t;

  // Index 0 is the top image row, index 2 the bottom row.
  typedef pixel_t [0:WIN-1] column_t;

  localparam logic MODE_MEDIAN = 1'b0;
  localparam logic MODE_GAUSS  = 1'b1;

  // Zero-extends a pixel into the Gaussian accumulator width.
  function automatic logic [8:0] extendPixel(input pixel_t p);
    return {4'b0000, p};
  endfunction

endpackage

// File: rtl/main_ctrl_unit_median9.sv
// Combinational exact median of nine pixels using a rank-count compare.
module median9
  import main_ctrl_pkg::*;
(
  input  pixel_t pix_i [9],
  output pixel_t median_o
);

  logic [3:0] rank [9];

  // Each pixel's rank is the number of pixels strictly ahead of it; equal
  // values are ordered by position so every rank 0..8 occurs exactly once.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      rank[i] = 4'd0;
      for (int j = 0; j < 9; j++) begin
        if (j != i) begin
          if ((pix_i[j] < pix_i[i]) || ((pix_i[j] == pix_i[i]) && (j < i))) begin
            rank[i] = rank[i] + 4'd1;
          end
        end
      end
    end
  end

  // Exactly one pixel holds rank 4, so OR-ing the masked pixels selects it.
  always_comb begin
    median_o = '0;
    for (int i = 0; i < 9; i++) begin
      if (rank[i] == 4'd4) begin
        median_o = median_o | pix_i[i];
      end
    end
  end

endmodule

// File: rtl/main_ctrl_unit.sv
// Streaming 3x3 filter core: sliding column window, fill counter, and a
// registered median/Gaussian output selected by mode.
module main_ctrl_unit
  import main_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic [PW-1:0] pixel_in0,
  input  logic [PW-1:0] pixel_in1,
  input  logic [PW-1:0] pixel_in2,
  output logic [PW-1:0] pixel_out
);

  // col2 is the oldest (left) column, col1 the centre, col0 the newest (right).
  column_t    col0_q, col1_q, col2_q;
  column_t    col0_d, col1_d, col2_d;
  logic [1:0] fillCount_q, fillCount_d;
  pixel_t     pixelOut_q, pixelOut_d;

  pixel_t     windowPix [9];
  pixel_t     medianPix;
  logic [8:0] gaussSum;
  pixel_t     gaussPix;

  // Flatten the window row-major (top..bottom, left..right) for the median.
  always_comb begin
    for (int r = 0; r < WIN; r++) begin
      windowPix[r*3 + 0] = col2_q[r];
      windowPix[r*3 + 1] = col1_q[r];
      windowPix[r*3 + 2] = col0_q[r];
    end
  end

  median9 u_median9 (
    .pix_i    (windowPix),
    .median_o (medianPix)
  );

  // 1-2-1 / 2-4-2 / 1-2-1 kernel; the peak sum of 496 fits in 9 bits and the
  // truncated divide by 16 always fits in a pixel.
  always_comb begin
    gaussSum = extendPixel(col2_q[0])        + (extendPixel(col1_q[0]) << 1) + extendPixel(col0_q[0])
             + (extendPixel(col2_q[1]) << 1) + (extendPixel(col1_q[1]) << 2) + (extendPixel(col0_q[1]) << 1)
             + extendPixel(col2_q[2])        + (extendPixel(col1_q[2]) << 1) + extendPixel(col0_q[2]);
    gaussPix = pixel_t'(gaussSum >> 4);
  end

  // Shift in one column per cycle, saturate the fill count, and compute a new
  // output from the pre-edge window only once three columns are present.
  always_comb begin
    col0_d[0]   = pixel_in0;
    col0_d[1]   = pixel_in1;
    col0_d[2]   = pixel_in2;
    col1_d      = col0_q;
    col2_d      = col1_q;
    fillCount_d = fillCount_q;
    pixelOut_d  = pixelOut_q;
    if (fillCount_q != 2'd3) begin
      fillCount_d = fillCount_q + 2'd1;
    end
    if (fillCount_q == 2'd3) begin
      pixelOut_d = (mode == MODE_GAUSS) ? gaussPix : medianPix;
    end
  end

  // State registers with synchronous reset; reset empties the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      col0_q      <= '0;
      col1_q      <= '0;
      col2_q      <= '0;
      fillCount_q <= 2'd0;
      pixelOut_q  <= '0;
    end else begin
      col0_q      <= col0_d;
      col1_q      <= col1_d;
      col2_q      <= col2_d;
      fillCount_q <= fillCount_d;
      pixelOut_q  <= pixelOut_d;
    end
  end

  assign pixel_out = pixelOut_q;

endmodule

// File: tb/tb_main_ctrl_unit.sv
// Directed self-checking bench for the streaming 3x3 filter core.
module tb_main_ctrl_unit;

  logic       clk;
  logic       reset;
  logic       mode;
  logic [4:0] pixel_in0;
  logic [4:0] pixel_in1;
  logic [4:0] pixel_in2;
  logic [4:0] pixel_out;

  int vectorCount;
  int missCount;

  main_ctrl_unit dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .pixel_in0 (pixel_in0),
    .pixel_in1 (pixel_in1),
    .pixel_in2 (pixel_in2),
    .pixel_out (pixel_out)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one column and mode, then step past the next rising edge.
  task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] c, input logic m);
    pixel_in0 = a;
    pixel_in1 = b;
    pixel_in2 = c;
    mode      = m;
    @(posedge clk);
    #1;
  endtask

  // One-cycle synchronous reset with idle inputs.
  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0);
    reset = 1'b0;
  endtask

  // Independent reference: insertion sort for the median, direct kernel sum
  // for the Gaussian. v is row-major, column 0 = left/oldest.
  function automatic logic [4:0] refFilter(input logic [4:0] v [9], input logic m);
    logic [4:0] s [9];
    logic [4:0] t;
    int         sum;
    int         wt;
    for (int i = 0; i < 9; i++) s[i] = v[i];
    for (int i = 1; i < 9; i++) begin
      for (int j = i; j > 0; j--) begin
        if (s[j] < s[j-1]) begin
          t = s[j]; s[j] = s[j-1]; s[j-1] = t;
        end
      end
    end
    sum = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        wt  = ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
        sum = sum + wt * int'(v[r*3 + c]);
      end
    end
    if (m) return 5'(sum / 16);
    return s[4];
  endfunction

  // Output must be zero straight out of reset.
  task automatic test_reset();
    applyReset();
    vectorCount++;
    if (pixel_out !== 5'd0) begin
      $display("[TB] FAIL reset_state: got %0d expected %0d", pixel_out, 0);
      missCount++;
    end
  endtask

  // Columns 1,2,3 with the median: zero through edge 3, then 2.
  task automatic test_median_fill();
    logic [4:0] expv [4];
    expv[0] = 5'd0; expv[1] = 5'd0; expv[2] = 5'd0; expv[3] = 5'd2;
    applyReset();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) applyStimulus(5'(k+1), 5'(k+1), 5'(k+1), 1'b0);
      else       applyStimulus(5'd0, 5'd0, 5'd0, 1'b0);
      vectorCount++;
      if (pixel_out !== expv[k]) begin
        $display("[TB] FAIL median_fill edge%0d: got %0d expected %0d", k+1, pixel_out, expv[k]);
        missCount++;
      end
    end
  endtask

  // Same columns with the Gaussian: (4*1 + 8*2 + 4*3)/16 = 2.
  task automatic test_gauss_fill();
    logic [4:0] expv [4];
    expv[0] = 5'd0; expv[1] = 5'd0; expv[2] = 5'd0; expv[3] = 5'd2;
    applyReset();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) applyStimulus(5'(k+1), 5'(k+1), 5'(k+1), 1'b1);
      else       applyStimulus(5'd0, 5'd0, 5'd0, 1'b1);
      vectorCount++;
      if (pixel_out !== expv[k]) begin
        $display("[TB] FAIL gauss_fill edge%0d: got %0d expected %0d", k+1, pixel_out, expv[k]);
        missCount++;
      end
    end
  endtask

  // All-31 window through the Gaussian must not overflow.
  task automatic test_gauss_max();
    logic [4:0] expv [5];
    expv[0] = 5'd0; expv[1] = 5'd0; expv[2] = 5'd0; expv[3] = 5'd31; expv[4] = 5'd31;
    applyReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(5'd31, 5'd31, 5'd31, 1'b1);
      vectorCount++;
      if (pixel_out !== expv[k]) begin
        $display("[TB] FAIL gauss_max edge%0d: got %0d expected %0d", k+1, pixel_out, expv[k]);
        missCount++;
      end
    end
  endtask

  // Centre impulse of 31: median rejects it, Gaussian gives 124/16 = 7.
  task automatic test_impulse();
    logic [4:0] expv [2];
    expv[0] = 5'd0; expv[1] = 5'd7;
    for (int m = 0; m < 2; m++) begin
      applyReset();
      applyStimulus(5'd0, 5'd0,  5'd0, 1'(m));
      applyStimulus(5'd0, 5'd31, 5'd0, 1'(m));
      applyStimulus(5'd0, 5'd0,  5'd0, 1'(m));
      applyStimulus(5'd0, 5'd0,  5'd0, 1'(m));
      vectorCount++;
      if (pixel_out !== expv[m]) begin
        $display("[TB] FAIL impulse mode%0d: got %0d expected %0d", m, pixel_out, expv[m]);
        missCount++;
      end
    end
  endtask

  // Mid-stream reset clears output at once and restarts the four-edge fill.
  task automatic test_reset_midstream();
    logic [4:0] expv [4];
    expv[0] = 5'd0; expv[1] = 5'd0; expv[2] = 5'd0; expv[3] = 5'd5;
    applyReset();
    for (int k = 0; k < 5; k++) applyStimulus(5'd31, 5'd31, 5'd31, 1'b0);
    applyReset();
    vectorCount++;
    if (pixel_out !== 5'd0) begin
      $display("[TB] FAIL midstream_reset: got %0d expected %0d", pixel_out, 0);
      missCount++;
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(5'd5, 5'd5, 5'd5, 1'b0);
      vectorCount++;
      if (pixel_out !== expv[k]) begin
        $display("[TB] FAIL refill edge%0d: got %0d expected %0d", k+1, pixel_out, expv[k]);
        missCount++;
      end
    end
  endtask

  // Ramp stream col k = {k,k,k} with mode toggling every cycle.
  task automatic test_mode_toggle_ramp();
    logic [4:0] win [9];
    logic [4:0] expv;
    logic [4:0] prev;
    logic       m;
    int         cnt;
    applyReset();
    for (int i = 0; i < 9; i++) win[i] = 5'd0;
    prev = 5'd0;
    cnt  = 0;
    for (int k = 0; k < 10; k++) begin
      m    = 1'(k % 2);
      expv = (cnt == 3) ? refFilter(win, m) : prev;
      applyStimulus(5'(k), 5'(k), 5'(k), m);
      for (int r = 0; r < 3; r++) begin
        win[r*3 + 0] = win[r*3 + 1];
        win[r*3 + 1] = win[r*3 + 2];
        win[r*3 + 2] = 5'(k);
      end
      if (cnt < 3) cnt++;
      prev = expv;
      vectorCount++;
      if (pixel_out !== expv) begin
        $display("[TB] FAIL ramp_toggle k%0d mode%0d: got %0d expected %0d", k, m, pixel_out, expv);
        missCount++;
      end
    end
  endtask

  // Rows carry unrelated values so median and Gaussian diverge; mode changes
  // irregularly and the window is never flushed between modes.
  task automatic test_mode_toggle_mixed();
    logic [4:0] win [9];
    logic [4:0] col [3];
    logic [4:0] expv;
    logic [4:0] prev;
    logic       m;
    int         cnt;
    applyReset();
    for (int i = 0; i < 9; i++) win[i] = 5'd0;
    prev = 5'd0;
    cnt  = 0;
    for (int k = 0; k < 14; k++) begin
      m = ((k % 3) == 1) ? 1'b1 : 1'b0;
      for (int r = 0; r < 3; r++) col[r] = 5'((k * 7 + r * 11 + (k * r * 5) + 3) % 32);
      expv = (cnt == 3) ? refFilter(win, m) : prev;
      applyStimulus(col[0], col[1], col[2], m);
      for (int r = 0; r < 3; r++) begin
        win[r*3 + 0] = win[r*3 + 1];
        win[r*3 + 1] = win[r*3 + 2];
        win[r*3 + 2] = col[r];
      end
      if (cnt < 3) cnt++;
      prev = expv;
      vectorCount++;
      if (pixel_out !== expv) begin
        $display("[TB] FAIL mixed_toggle k%0d mode%0d: got %0d expected %0d", k, m, pixel_out, expv);
        missCount++;
      end
    end
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    vectorCount = 0;
    missCount   = 0;
    reset       = 1'b1;
    mode        = 1'b0;
    pixel_in0   = 5'd0;
    pixel_in1   = 5'd0;
    pixel_in2   = 5'd0;
    #2;
    test_reset();
    test_median_fill();
    test_gauss_fill();
    test_gauss_max();
    test_impulse();
    test_reset_midstream();
    test_mode_toggle_ramp();
    test_mode_toggle_mixed();
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
